ghash_stream: RTL and testbench
===============================

Name: ghash_stream

Overview:
Parametrised GHASH engine for full AES-GCM streams. It takes AAD blocks and then ciphertext blocks on one valid/ready input, zero-pads partial blocks and counts bit lengths per class. After the last block it appends the len(A)||len(C) block itself and presents the final GHASH value on a valid/ready output. It sits between the AES-CTR datapath and tag generation, and reuses the existing gf128_mul, driven by its valid_i/valid_o pulses.

Parameters:
FIFO_DEPTH, 8, input buffer entries; power of two, >=2
LEN_W, 64, internal bit-length counter width per class (<=64); value zero-extended into the 64-bit length fields

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
h_i  in  128  hash subkey H, GCM bit order (MSB = x^0)
h_valid_i  in  1  load H; accepted only in S_NOH/S_IDLE
din_i  in  128  data block; byte 0 = din_i[127:120]
din_keep_i  in  16  byte-valid mask, bit 15 = byte 0; contiguous from bit 15
din_aad_i  in  1  1 = AAD block, 0 = ciphertext block
din_last_i  in  1  final block of message
din_valid_i  in  1  input valid
din_ready_o  out  1  input ready
dout_o  out  128  GHASH result, GCM bit order
dout_valid_o  out  1  result valid
dout_ready_i  in  1  result accepted
busy_o  out  1  message in progress
err_o  out  1  sticky protocol error; cleared by reset or the next h_valid_i

Behaviour:
- Clocking/reset: single clk; asynchronous active-low rst_n. Reset forces din_ready_o=0, dout_valid_o=0, dout_o=0, busy_o=0, err_o=0, FIFO empty, accumulator Y=0, counters 0, state S_NOH. Reset mid-message discards everything, and H must be reloaded.
- Input transfer occurs on din_valid_i & din_ready_o. din_ready_o = !fifo_full & state!=S_NOH & state!=S_OUT & !last_seen. last_seen is set when the last block is pushed and cleared on the output handshake.
- On push, bytes with keep=0 are zeroed. The AAD or C counter (selected by din_aad_i) adds 8*popcount(keep). A block with keep=0 is counted as 0 and is not multiplied; it is only legal as the last block, to mark an empty message.
- Errors (err_o set, block still processed as stated):
  - a non-last block with keep!=16'hFFFF
  - an AAD block after any C block in the same message
  - counter overflow; the counter saturates
- FSM:
  - S_NOH: waits for h_valid_i, which stores H and moves to S_IDLE.
  - S_IDLE: h_valid_i reloads H. A non-empty FIFO moves to S_ACCUM and sets busy_o.
  - S_ACCUM: pops the head only when no multiply is outstanding. Issues mul(Y^block, H). On valid_o, Y <= result. When the popped block is last and its multiply (if any) has completed, moves to S_LEN.
  - S_LEN: issues mul(Y ^ {lenA[63:0], lenC[63:0]}, H) and moves to S_WAIT.
  - S_WAIT: on valid_o, moves to S_OUT with dout_o = result and dout_valid_o = 1.
  - S_OUT: dout_o and dout_valid_o hold until dout_ready_i. On the handshake: Y, counters and last_seen clear; busy_o drops; state goes to S_IDLE next cycle.
- Only one multiply is in flight at a time. Throughput is one block per (gf128_mul latency + 1) cycles. Final latency from the last pop is (blocks left + 1) multiplies + 1 cycle.
- Pushes of the next message may not start until after the output handshake (enforced by last_seen).
- h_valid_i outside S_NOH/S_IDLE is ignored and sets err_o.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, but din_ready_o stays low that cycle because it is computed from registered full.

Test Plan:
1. H=66e94bd4ef8a2c3b884cfa59ca342b2e; one block keep=0, last, aad=0 -> dout_o=0 after one length multiply; err_o=0.
2. Same H; C=0388dace60b6a392f328c2b971b2fe78, keep=FFFF, aad=0, last -> dout_o=f38cbb1ad69223dcc3457ae5b6b0f885; length block 0…0|0…080.
3. Partial block: C as test 2 with keep=FFF0 -> hashed block has bytes 12-15 zeroed; lenC=96; result matches software model; err_o=0.
4. Backpressure: 10 full blocks pushed back to back with FIFO_DEPTH=8 and dout_ready_i=0 for 20 cycles after dout_valid_o -> din_ready_o drops at 8 buffered; no block lost; dout_o stable while held; model-matched result.
5. Ordering error: C block then AAD block -> err_o=1 and stays 1; next h_valid_i clears it.
6. Reset asserted in S_WAIT -> all outputs 0 immediately; din_ready_o=0 until H is reloaded; a fresh message after reload gives the correct result.

Source files
------------

// File: rtl/ghash_stream.sv
// GHASH engine for AES-GCM streams: buffers AAD/C blocks, zero-pads partials,
// tracks bit lengths, appends len(A)||len(C) and returns the final hash.
module ghash_stream #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] h_i,
  input  logic         h_valid_i,
  input  logic [127:0] din_i,
  input  logic [15:0]  din_keep_i,
  input  logic         din_aad_i,
  input  logic         din_last_i,
  input  logic         din_valid_i,
  output logic         din_ready_o,
  output logic [127:0] dout_o,
  output logic         dout_valid_o,
  input  logic         dout_ready_i,
  output logic         busy_o,
  output logic         err_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = LEN_W + 1;

  typedef enum logic [2:0] {S_NOH, S_IDLE, S_ACCUM, S_LEN, S_WAIT, S_OUT} state_e;
  typedef struct packed {
    logic [127:0] data;
    logic         nz;
    logic         last;
  } entry_t;

  state_e           state_q, state_d;
  logic [127:0]     h_q, h_d, y_q, y_d, dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d, busy_q, busy_d, err_q, err_d;
  logic             last_seen_q, last_seen_d, c_seen_q, c_seen_d;
  logic             last_popped_q, last_popped_d, mul_busy_q, mul_busy_d;
  logic [LEN_W-1:0] len_a_q, len_a_d, len_c_q, len_c_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           head;

  logic             fifo_empty, fifo_full, push;
  logic [127:0]     masked;
  logic [7:0]       add_bits;
  logic [SW-1:0]    sum_a, sum_c;
  logic             mul_valid_c, mul_done;
  logic [127:0]     mul_a_c, mul_p;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign din_ready_o = !fifo_full && (state_q != S_NOH) && (state_q != S_OUT) && !last_seen_q;
  assign push        = din_valid_i && din_ready_o;
  assign head        = mem_q[rd_ptr_q[AW-1:0]];

  // keep bit k guards din_i[8k+7:8k] (bit 15 = byte 0 = MSB byte)
  always_comb begin
    masked = din_i;
    for (int k = 0; k < 16; k++) begin
      if (!din_keep_i[k]) masked[8*k +: 8] = 8'h00;
    end
  end

  assign add_bits = 8'(8 * $countones(din_keep_i));
  assign sum_a    = {1'b0, len_a_q} + SW'(add_bits);
  assign sum_c    = {1'b0, len_c_q} + SW'(add_bits);

  gf128_mul u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (mul_valid_c),
    .a_i     (mul_a_c),
    .b_i     (h_q),
    .valid_o (mul_done),
    .p_o     (mul_p)
  );

  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    y_d           = y_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    busy_d        = busy_q;
    err_d         = err_q;
    last_seen_d   = last_seen_q;
    c_seen_d      = c_seen_q;
    last_popped_d = last_popped_q;
    mul_busy_d    = mul_busy_q;
    len_a_d       = len_a_q;
    len_c_d       = len_c_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mul_valid_c   = 1'b0;
    mul_a_c       = '0;

    if (h_valid_i) begin
      if (state_q == S_NOH || state_q == S_IDLE) begin
        h_d   = h_i;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // push side: length accounting and protocol checks
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (din_last_i) last_seen_d = 1'b1;
      if (!din_aad_i) c_seen_d = 1'b1;
      if (!din_last_i && din_keep_i != 16'hFFFF) err_d = 1'b1;
      if (din_aad_i && c_seen_q) err_d = 1'b1;
      if (din_aad_i) begin
        if (sum_a[LEN_W]) begin
          len_a_d = '1;
          err_d   = 1'b1;
        end else begin
          len_a_d = sum_a[LEN_W-1:0];
        end
      end else begin
        if (sum_c[LEN_W]) begin
          len_c_d = '1;
          err_d   = 1'b1;
        end else begin
          len_c_d = sum_c[LEN_W-1:0];
        end
      end
    end

    case (state_q)
      S_NOH: if (h_valid_i) state_d = S_IDLE;
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_ACCUM;
          busy_d  = 1'b1;
        end
      end
      S_ACCUM: begin
        if (!mul_busy_q && !last_popped_q && !fifo_empty) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (head.nz) begin
            mul_valid_c = 1'b1;
            mul_a_c     = y_q ^ head.data;
            mul_busy_d  = 1'b1;
          end
          if (head.last) last_popped_d = 1'b1;
        end else if (last_popped_q && !mul_busy_q) begin
          state_d = S_LEN;
        end
        if (mul_done) begin
          y_d        = mul_p;
          mul_busy_d = 1'b0;
        end
      end
      S_LEN: begin
        mul_valid_c = 1'b1;
        mul_a_c     = y_q ^ {64'(len_a_q), 64'(len_c_q)};
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          dout_d       = mul_p;
          dout_valid_d = 1'b1;
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        if (dout_ready_i) begin
          dout_valid_d  = 1'b0;
          y_d           = '0;
          len_a_d       = '0;
          len_c_d       = '0;
          last_seen_d   = 1'b0;
          c_seen_d      = 1'b0;
          last_popped_d = 1'b0;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_NOH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_NOH;
      h_q           <= '0;
      y_q           <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      last_seen_q   <= 1'b0;
      c_seen_q      <= 1'b0;
      last_popped_q <= 1'b0;
      mul_busy_q    <= 1'b0;
      len_a_q       <= '0;
      len_c_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      y_q           <= y_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      last_seen_q   <= last_seen_d;
      c_seen_q      <= c_seen_d;
      last_popped_q <= last_popped_d;
      mul_busy_q    <= mul_busy_d;
      len_a_q       <= len_a_d;
      len_c_q       <= len_c_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // buffer storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {masked, |din_keep_i, din_last_i};
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
endmodule

// Bit-serial GF(2^128) multiplier in GCM bit order (Horner, x^127 term first);
// 128-cycle latency, one-cycle valid_o pulse with p_o holding the product.
module gf128_mul (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [127:0] a_i,
  input  logic [127:0] b_i,
  output logic         valid_o,
  output logic [127:0] p_o
);
  logic [127:0] x_q, b_q, z_q, z_x;
  logic [6:0]   cnt_q;
  logic         run_q, valid_q;

  // z*x with reduction by x^128 + x^7 + x^2 + x + 1
  assign z_x = z_q[0] ? ((z_q >> 1) ^ {8'he1, 120'h0}) : (z_q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= run_q && (cnt_q == 7'd127);
      if (valid_i) begin
        x_q   <= a_i;
        b_q   <= b_i;
        z_q   <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        z_q   <= z_x ^ (x_q[0] ? b_q : 128'h0);
        x_q   <= x_q >> 1;
        cnt_q <= cnt_q + 7'd1;
        if (cnt_q == 7'd127) run_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign p_o     = z_q;
endmodule

// File: tb/tb_ghash_stream.sv
// Directed bench for ghash_stream with a reference GHASH model.
module tb_ghash_stream;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] h_i;
  logic         h_valid_i;
  logic [127:0] din_i;
  logic [15:0]  din_keep_i;
  logic         din_aad_i, din_last_i, din_valid_i, din_ready_o;
  logic [127:0] dout_o;
  logic         dout_valid_o, dout_ready_i, busy_o, err_o;

  int n_vec  = 0;
  int n_miss = 0;
  int acc_cnt;
  int first_low;

  logic [127:0] m_h, m_y;
  logic [63:0]  m_lena, m_lenc;

  localparam logic [127:0] H0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C0  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] T2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  ghash_stream #(.FIFO_DEPTH(8), .LEN_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_i          (h_i),
    .h_valid_i    (h_valid_i),
    .din_i        (din_i),
    .din_keep_i   (din_keep_i),
    .din_aad_i    (din_aad_i),
    .din_last_i   (din_last_i),
    .din_valid_i  (din_valid_i),
    .din_ready_o  (din_ready_o),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // NIST SP800-38D Algorithm 1 (shift-V form)
  function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] pad(input logic [127:0] d, input logic [15:0] k);
    for (int j = 0; j < 16; j++) begin
      if (!k[15-j]) d[127-8*j -: 8] = 8'h00;
    end
    return d;
  endfunction

  task automatic model_reset();
    m_y    = '0;
    m_lena = '0;
    m_lenc = '0;
  endtask

  function automatic logic [127:0] model_final();
    return gmul(m_y ^ {m_lena, m_lenc}, m_h);
  endfunction

  task automatic load_h(input logic [127:0] h);
    h_i       = h;
    h_valid_i = 1'b1;
    m_h       = h;
    @(posedge clk); #1;
    h_valid_i = 1'b0;
  endtask

  task automatic push(input logic [127:0] d, input logic [15:0] k, input logic aad, input logic last);
    int n;
    din_i       = d;
    din_keep_i  = k;
    din_aad_i   = aad;
    din_last_i  = last;
    din_valid_i = 1'b1;
    n = 0;
    while (!din_ready_o && n < 3000) begin
      if (first_low < 0) first_low = acc_cnt;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("push_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    din_valid_i = 1'b0;
    acc_cnt++;
    if (k != 16'h0) m_y = gmul(m_y ^ pad(d, k), m_h);
    if (aad) m_lena = m_lena + 64'(8 * $countones(k));
    else     m_lenc = m_lenc + 64'(8 * $countones(k));
  endtask

  task automatic get_result(input string tag, input logic [127:0] exp, input int hold);
    int n;
    logic [127:0] v;
    logic stable;
    n = 0;
    while (!dout_valid_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 128'(dout_valid_o), 128'd1);
    chk({tag, "_dout"}, dout_o, exp);
    v = dout_o;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!dout_valid_o || dout_o !== v) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold"}, 128'(stable), 128'd1);
    dout_ready_i = 1'b1;
    @(posedge clk); #1;
    dout_ready_i = 1'b0;
    chk({tag, "_vdrop"}, 128'(dout_valid_o), 128'd0);
    chk({tag, "_busy"}, 128'(busy_o), 128'd0);
  endtask

  initial begin
    logic [127:0] exp;
    rst_n = 1'b0; h_i = '0; h_valid_i = 1'b0; din_i = '0; din_keep_i = '0;
    din_aad_i = 1'b0; din_last_i = 1'b0; din_valid_i = 1'b0; dout_ready_i = 1'b0;
    acc_cnt = 0; first_low = 0;
    m_h = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(din_ready_o), 128'd0);
    chk("rst_dvalid", 128'(dout_valid_o), 128'd0);
    chk("rst_dout", dout_o, 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_err", 128'(err_o), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("noh_ready", 128'(din_ready_o), 128'd0);

    // 1: empty message -> only length block multiply of zero
    load_h(H0);
    chk("h_ready", 128'(din_ready_o), 128'd1);
    model_reset();
    push(128'h0, 16'h0000, 1'b0, 1'b1);
    get_result("t1", 128'h0, 0);
    chk("t1_err", 128'(err_o), 128'd0);

    // 2: single full C block, published vector
    model_reset();
    push(C0, 16'hFFFF, 1'b0, 1'b1);
    get_result("t2", T2, 0);
    chk("t2_model", model_final(), T2);
    chk("t2_err", 128'(err_o), 128'd0);

    // 3: 12-byte partial C block
    model_reset();
    push(C0, 16'hFFF0, 1'b0, 1'b1);
    exp = gmul(gmul(C0 & {96'hffffffff_ffffffff_ffffffff, 32'h0}, H0) ^ {64'd0, 64'd96}, H0);
    get_result("t3", exp, 0);
    chk("t3_err", 128'(err_o), 128'd0);

    // 4: 2 AAD + 8 C blocks back to back with output backpressure
    model_reset();
    acc_cnt = 0;
    first_low = -1;
    for (int i = 0; i < 10; i++) begin
      push({4{32'h9e3779b9 * 32'(i + 1)}} ^ {32'(i), 96'h0}, 16'hFFFF, (i < 2), (i == 9));
    end
    chk("t4_ready_drop_at", 128'(first_low), 128'd9);
    get_result("t4", model_final(), 20);
    chk("t4_err", 128'(err_o), 128'd0);

    // 5: AAD after C -> sticky error, cleared by next H load
    model_reset();
    push(C0, 16'hFFFF, 1'b0, 1'b0);
    push(~C0, 16'hFFFF, 1'b1, 1'b1);
    chk("t5_err", 128'(err_o), 128'd1);
    get_result("t5", model_final(), 0);
    chk("t5_err_sticky", 128'(err_o), 128'd1);
    load_h(H0);
    chk("t5_err_clear", 128'(err_o), 128'd0);

    // 6: reset while waiting on the length multiply
    model_reset();
    push(C0, 16'hFFFF, 1'b0, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    chk("t6_busy_pre", 128'(busy_o), 128'd1);
    chk("t6_dvalid_pre", 128'(dout_valid_o), 128'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 128'(busy_o), 128'd0);
    chk("t6_rst_ready", 128'(din_ready_o), 128'd0);
    chk("t6_rst_dvalid", 128'(dout_valid_o), 128'd0);
    chk("t6_rst_dout", dout_o, 128'd0);
    chk("t6_rst_err", 128'(err_o), 128'd0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_noh_ready", 128'(din_ready_o), 128'd0);
    load_h(H0);
    chk("t6_h_ready", 128'(din_ready_o), 128'd1);
    model_reset();
    push(C0, 16'hFFFF, 1'b0, 1'b1);
    get_result("t6", T2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
